// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage.
//   Owns the PC and issues one word request per cycle to a synchronous
//   instruction memory with 1-cycle read latency. Returned words are buffered
//   in a FIFO and presented to decode as {pc, inst} through a valid/ready
//   handshake. A branch redirect flushes buffered and in-flight fetches.
//
// Optional feature macro: IFU_ADEF_EN
//   Defined   : a misaligned redirect target produces one fetch-address
//               exception entry and halts fetch until the next redirect/reset.
//   Undefined : target[1:0] is cleared and fetch proceeds normally.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   branch_flag_i/target_i      redirect request and target from EX
//   inst_req_o, inst_addr_o     memory request enable and address
//   inst_rdata_i                memory read data (cycle after request)
//   inst_valid_o, id_ready_i    FIFO head handshake with decode
//   pc_o, inst_o, excp_adef_o   FIFO head payload (0 when empty)
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h1c00_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_rdata_i,
  output logic        inst_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        excp_adef_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic          inflight_q;
  logic          halt_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;

  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] inst_mem [FIFO_DEPTH];

  logic          deq;
  logic          enq;
  logic [31:0]   enq_pc;
  logic [31:0]   enq_inst;
  logic [31:0]   redirect_pc;
  logic [CW:0]   occ;

`ifdef IFU_ADEF_EN
  logic adef_mem [FIFO_DEPTH];
  logic adef_pend_q;
  logic misaligned;

  assign misaligned  = (branch_target_i[1:0] != 2'b00);
  assign redirect_pc = branch_target_i;

  // The pending exception entry carries the (halted) redirect target held in pc_q.
  assign enq      = (inflight_q | adef_pend_q) & ~branch_flag_i;
  assign enq_pc   = adef_pend_q ? pc_q : req_pc_q;
  assign enq_inst = adef_pend_q ? 32'h0 : inst_rdata_i;
`else
  assign halt_q      = 1'b0;
  assign redirect_pc = branch_target_i & 32'hffff_fffc;

  assign enq      = inflight_q & ~branch_flag_i;
  assign enq_pc   = req_pc_q;
  assign enq_inst = inst_rdata_i;
`endif

  assign inst_valid_o = (count_q != '0);
  assign deq          = inst_valid_o & id_ready_i;

  // Entries buffered plus in flight after this cycle's dequeue must leave room.
  assign occ         = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(deq);
  assign inst_req_o  = ~rst & ~branch_flag_i & ~halt_q & (occ < DEPTH_OCC);
  assign inst_addr_o = rst ? 32'h0 : pc_q;

  // Head payload, forced to zero when the FIFO is empty.
  always_comb begin
    pc_o        = 32'h0;
    inst_o      = 32'h0;
    excp_adef_o = 1'b0;
    if (inst_valid_o) begin
      pc_o   = pc_mem[rd_ptr_q];
      inst_o = inst_mem[rd_ptr_q];
`ifdef IFU_ADEF_EN
      excp_adef_o = adef_mem[rd_ptr_q];
`endif
    end
  end

  // PC, in-flight tracking and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (branch_flag_i) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      if (inst_req_o) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
      inflight_q <= inst_req_o;
      if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end

`ifdef IFU_ADEF_EN
  // Misaligned redirect: halt fetch and queue one exception entry next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q      <= 1'b0;
      adef_pend_q <= 1'b0;
    end else if (branch_flag_i) begin
      halt_q      <= misaligned;
      adef_pend_q <= misaligned;
    end else begin
      adef_pend_q <= 1'b0;
    end
  end
`endif

  // FIFO storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (~rst & enq) begin
      pc_mem[wr_ptr_q]   <= enq_pc;
      inst_mem[wr_ptr_q] <= enq_inst;
`ifdef IFU_ADEF_EN
      adef_mem[wr_ptr_q] <= adef_pend_q;
`endif
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed scenarios with values taken from the
// fetch rules, then a randomized run checked against a queue-based model.
module tb_ifu_fetch;

  localparam logic [31:0] RPC   = 32'h1c00_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        id_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        adef;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .inst_req_o      (inst_req),
    .inst_addr_o     (inst_addr),
    .inst_rdata_i    (inst_rdata),
    .inst_valid_o    (inst_valid),
    .id_ready_i      (id_ready),
    .pc_o            (pc),
    .inst_o          (inst),
    .excp_adef_o     (adef)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'ha5a5_0f0f;
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) inst_rdata <= inst_req ? mem_word(inst_addr) : 32'hdead_beef;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_flag = 1'b0;
    id_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    id_ready = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%h exp=0", inst_req); end
    checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", inst_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", inst_valid); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
    checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
    checks++; if (adef !== 1'b0) begin failures++; $display("FAIL reset_adef got=%h exp=0", adef); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (inst_req !== 1'b1 || inst_addr !== RPC) begin
      failures++; $display("FAIL reset_first_req got=%h/%h exp=1/%h", inst_req, inst_addr, RPC);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    id_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      e = RPC + 32'(4 * c);
      checks++; if (inst_req !== 1'b1 || inst_addr !== e) begin
        failures++; $display("FAIL stream_req c=%0d got=%h/%h exp=1/%h", c, inst_req, inst_addr, e);
      end
      checks++; if (inst_valid !== (c >= 2)) begin
        failures++; $display("FAIL stream_valid c=%0d got=%h exp=%0d", c, inst_valid, c >= 2);
      end
      if (c >= 2) begin
        e = RPC + 32'(4 * (c - 2));
        checks++; if (pc !== e || inst !== mem_word(e)) begin
          failures++; $display("FAIL stream_head c=%0d got=%h/%h exp=%h/%h", c, pc, inst, e, mem_word(e));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset();
    exp_pc = RPC;
    for (int c = 0; c < 16; c++) begin
      id_ready = (c < 3 || c >= 8);
      @(negedge clk);
      if (!id_ready) begin
        checks++; if (inst_req !== 1'b0) begin
          failures++; $display("FAIL stall_req c=%0d got=%h exp=0", c, inst_req);
        end
        checks++; if (inst_valid !== 1'b1 || pc !== exp_pc) begin
          failures++; $display("FAIL stall_head c=%0d got=%h/%h exp=1/%h", c, inst_valid, pc, exp_pc);
        end
      end else if (c >= 2) begin
        checks++; if (inst_valid !== 1'b1 || pc !== exp_pc) begin
          failures++; $display("FAIL stall_order c=%0d got=%h/%h exp=1/%h", c, inst_valid, pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (c == 8) begin
        checks++; if (inst_req !== 1'b1) begin
          failures++; $display("FAIL stall_resume got=%h exp=1", inst_req);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] t;
    t = 32'h1c00_0100;
    do_reset();
    id_ready = 1'b1;
    repeat (4) tick();
    branch_flag = 1'b1;
    branch_target = t;
    @(negedge clk);
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL redir_req_t got=%h exp=0", inst_req); end
    tick();
    branch_flag = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%h exp=0", inst_valid); end
    checks++; if (inst_req !== 1'b1 || inst_addr !== t) begin
      failures++; $display("FAIL redir_req_t1 got=%h/%h exp=1/%h", inst_req, inst_addr, t);
    end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || inst_addr !== t + 32'd4) begin
      failures++; $display("FAIL redir_t2 got=%h/%h exp=0/%h", inst_valid, inst_addr, t + 32'd4);
    end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || pc !== t || inst !== mem_word(t)) begin
      failures++; $display("FAIL redir_head got=%h/%h/%h exp=1/%h/%h", inst_valid, pc, inst, t, mem_word(t));
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    do_reset();
    id_ready = 1'b1;
    tick();
    branch_flag = 1'b1;
    branch_target = 32'hffff_fff8;
    tick();
    branch_flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = 32'hffff_fff8 + 32'(4 * k);
      checks++; if (inst_req !== 1'b1 || inst_addr !== e) begin
        failures++; $display("FAIL wrap_req k=%0d got=%h/%h exp=1/%h", k, inst_req, inst_addr, e);
      end
      tick();
    end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || pc !== 32'hffff_fffc) begin
      failures++; $display("FAIL wrap_head got=%h/%h exp=1/fffffffc", inst_valid, pc);
    end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || pc !== 32'h0) begin
      failures++; $display("FAIL wrap_head0 got=%h/%h exp=1/0", inst_valid, pc);
    end
    tick();
  endtask

  task automatic test_misaligned();
    do_reset();
    id_ready = 1'b1;
    tick();
    branch_flag = 1'b1;
    branch_target = 32'h1c00_0102;
    @(negedge clk);
    checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL mis_req_t got=%h exp=0", inst_req); end
    tick();
    branch_flag = 1'b0;
`ifdef IFU_ADEF_EN
    @(negedge clk);
    checks++; if (inst_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL mis_t1 got=%h/%h exp=0/0", inst_req, inst_valid);
    end
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || pc !== 32'h1c00_0102 || inst !== 32'h0 || adef !== 1'b1) begin
      failures++; $display("FAIL mis_adef got=%h/%h/%h/%h exp=1/1c000102/0/1", inst_valid, pc, inst, adef);
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL mis_halt k=%0d got=%h exp=0", k, inst_req); end
      tick();
      @(negedge clk);
    end
    branch_flag = 1'b1;
    branch_target = 32'h1c00_0200;
    tick();
    branch_flag = 1'b0;
    @(negedge clk);
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c00_0200) begin
      failures++; $display("FAIL mis_resume got=%h/%h exp=1/1c000200", inst_req, inst_addr);
    end
`else
    @(negedge clk);
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c00_0100) begin
      failures++; $display("FAIL mis_align got=%h/%h exp=1/1c000100", inst_req, inst_addr);
    end
    tick();
    tick();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || pc !== 32'h1c00_0100 || adef !== 1'b0) begin
      failures++; $display("FAIL mis_head got=%h/%h/%h exp=1/1c000100/0", inst_valid, pc, adef);
    end
`endif
    tick();
  endtask

  // Reference model: buffered entries as a queue plus a single in-flight slot.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    ent_t        head, ne;
    logic [31:0] m_pc, m_req_pc, e_addr, tgt;
    bit          m_infl, m_halt, m_pend, e_valid, e_req, deq;
    int          r;
    do_reset();
    q.delete();
    m_pc = RPC; m_req_pc = 32'h0; m_infl = 0; m_halt = 0; m_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      branch_flag = ($urandom_range(0, 15) == 0);
      r = int'($urandom_range(0, 3));
      if (r == 0) tgt = 32'hffff_fff0 + 32'($urandom_range(0, 15));
      else tgt = RPC + (32'($urandom_range(0, 63)) << 2) + ((r == 1) ? 32'($urandom_range(0, 3)) : 32'h0);
      branch_target = tgt;
      id_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      e_valid = (q.size() != 0);
      head = e_valid ? q[0] : '0;
      deq = e_valid && id_ready;
      e_req = !rst && !branch_flag && !m_halt && (q.size() + int'(m_infl) - int'(deq) < DEPTH);
      e_addr = rst ? 32'h0 : m_pc;
      checks++; if (inst_req !== e_req || inst_addr !== e_addr) begin
        failures++; $display("FAIL rnd_req n=%0d got=%h/%h exp=%h/%h", n, inst_req, inst_addr, e_req, e_addr);
      end
      checks++; if (inst_valid !== e_valid || pc !== head.pc || inst !== head.inst || adef !== head.adef) begin
        failures++; $display("FAIL rnd_head n=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", n,
                             inst_valid, pc, inst, adef, e_valid, head.pc, head.inst, head.adef);
      end
      if (rst) begin
        q.delete();
        m_pc = RPC; m_infl = 0; m_halt = 0; m_pend = 0;
      end else if (branch_flag) begin
        q.delete();
        m_infl = 0;
`ifdef IFU_ADEF_EN
        m_halt = (tgt[1:0] != 2'b00);
        m_pend = m_halt;
        m_pc = tgt;
`else
        m_pc = tgt & 32'hffff_fffc;
`endif
      end else begin
        if (deq) void'(q.pop_front());
        if (m_infl) begin
          ne.pc = m_req_pc; ne.inst = mem_word(m_req_pc); ne.adef = 1'b0;
          q.push_back(ne);
        end
        if (m_pend) begin
          ne.pc = m_pc; ne.inst = 32'h0; ne.adef = 1'b1;
          q.push_back(ne);
        end
        m_pend = 0;
        if (e_req) begin
          m_req_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
        m_infl = e_req;
      end
      tick();
    end
    rst = 1'b0;
    branch_flag = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_misaligned();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
